// File: rtl/ln_pkg.sv
// Shared types and defaults for the LayerNorm stage-2 stream controller.
package ln_pkg;

    localparam int unsigned LN_DAT_DW    = 16;
    localparam int unsigned LN_TOUT      = 32;
    localparam int unsigned LN_BURST_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } ln_state_e;

    // Ceiling log2, used for burst-length shifts and masks.
    function automatic int unsigned ln_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/ln_delay_pipe.sv
// Fixed-latency strobe+payload delay line; only the strobe is reset.
module ln_delay_pipe #(
    parameter int unsigned W   = 1,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_in,
    input  logic [W-1:0] dat_in,
    output logic         en_out,
    output logic [W-1:0] dat_out
);

    logic [LAT-1:0] en_sr;
    logic [W-1:0]   dat_sr [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sr <= '0;
        end else begin
            en_sr[0] <= en_in;
            for (int i = 1; i < int'(LAT); i++) en_sr[i] <= en_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dat_sr[0] <= dat_in;
        for (int i = 1; i < int'(LAT); i++) dat_sr[i] <= dat_sr[i-1];
    end

    // Payload is masked when idle so the un-reset data never leaks out.
    assign en_out  = en_sr[LAT-1];
    assign dat_out = en_out ? dat_sr[LAT-1] : '0;

endmodule

// File: rtl/ln_stream_ctrl.sv
// LayerNorm stage-2 read sequencer: credit-gated beat intake, h/wb/ch/w walk,
// and delayed weight/bias buffer reads.
module ln_stream_ctrl
    import ln_pkg::*;
#(
    parameter int unsigned DAT_DW     = LN_DAT_DW,
    parameter int unsigned TOUT       = LN_TOUT,
    parameter int unsigned BURST_LEN  = LN_BURST_LEN,
    parameter int unsigned CREDIT_MAX = 4,
    parameter int unsigned H_W        = 12,
    parameter int unsigned W_W        = 12,
    parameter int unsigned CHG_W      = 6,
    parameter int unsigned PIX_AW     = 12,
    parameter int unsigned WT_LAT     = 1,
    parameter int unsigned BIAS_LAT   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     rms_mode,
    input  logic                     credit_vld,
    input  logic [CHG_W-1:0]         ch_div_tout,
    input  logic [H_W-1:0]           h_in,
    input  logic [W_W-1:0]           w_in,
    input  logic                     rd_resp_vld,
    output logic                     rd_resp_rdy,
    input  logic [DAT_DW*TOUT-1:0]   rd_resp_pd,
    output logic                     rd_fifo_pop,
    output logic                     busy,
    output logic                     done,
    output logic [DAT_DW*TOUT-1:0]   feat_pd,
    output logic                     feat_vld,
    output logic                     rd_dat_en,
    output logic [PIX_AW-1:0]        rd_dat_addr,
    output logic                     rd_wt_en,
    output logic [CHG_W-1:0]         rd_wt_addr,
    output logic                     rd_bias_en,
    output logic [CHG_W-1:0]         rd_bias_addr
);

    localparam int unsigned PD_W   = DAT_DW * TOUT;
    localparam int unsigned BL_LOG = ln_log2(BURST_LEN);
    localparam int unsigned CRD_W  = $clog2(CREDIT_MAX + 1);
    localparam int unsigned ADR_W  = H_W + W_W + 1;

    ln_state_e        state_q, state_d;
    logic [H_W-1:0]   h_cfg;
    logic [W_W-1:0]   w_cfg;
    logic [CHG_W-1:0] chg_cfg;
    logic             rms_cfg;
    logic [H_W-1:0]   h_cnt;
    logic [W_W-1:0]   wb_cnt;
    logic [CHG_W-1:0] ch_cnt;
    logic [W_W-1:0]   w_cnt;
    logic [CRD_W-1:0] credit_cnt;

    logic             acc;
    logic             cfg_load;
    logic             cnt_clr;
    logic             shape_empty;
    logic [W_W-1:0]   wb_max;
    logic [W_W-1:0]   cur_len;
    logic             last_w, last_ch, last_wb, last_h, last_beat;

    assign rd_resp_rdy = (state_q == RUN) && (credit_cnt != '0);
    assign acc         = rd_resp_vld && rd_resp_rdy;
    assign rd_fifo_pop = acc;
    assign rd_dat_en   = acc;
    assign busy        = (state_q != IDLE);

    assign shape_empty = (h_in == '0) || (w_in == '0) || (ch_div_tout == '0);

    // Last burst of a row may be short: its length comes from the low bits of w.
    assign wb_max    = (w_cfg - W_W'(1)) >> BL_LOG;
    assign last_wb   = (wb_cnt == wb_max);
    assign cur_len   = last_wb ? ((w_cfg - W_W'(1)) & W_W'(BURST_LEN - 1))
                               : W_W'(BURST_LEN - 1);
    assign last_w    = (w_cnt == cur_len);
    assign last_ch   = (ch_cnt == chg_cfg - CHG_W'(1));
    assign last_h    = (h_cnt == h_cfg - H_W'(1));
    assign last_beat = last_w && last_ch && last_wb && last_h;

    assign rd_dat_addr = PIX_AW'(ADR_W'(h_cnt) * ADR_W'(w_cfg)
                                + (ADR_W'(wb_cnt) << BL_LOG)
                                + ADR_W'(w_cnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cfg_load = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = shape_empty ? ZERO : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (acc && last_beat) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            ZERO: begin
                done    = !abort;
                cnt_clr = abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cfg   <= '0;
            w_cfg   <= '0;
            chg_cfg <= '0;
            rms_cfg <= 1'b0;
        end else if (cfg_load) begin
            h_cfg   <= h_in;
            w_cfg   <= w_in;
            chg_cfg <= ch_div_tout;
            rms_cfg <= rms_mode;
        end
    end

    // Loop nest, innermost first: w -> ch -> wb -> h.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt  <= '0;
            ch_cnt <= '0;
            wb_cnt <= '0;
            h_cnt  <= '0;
        end else if (cnt_clr) begin
            w_cnt  <= '0;
            ch_cnt <= '0;
            wb_cnt <= '0;
            h_cnt  <= '0;
        end else if (acc) begin
            w_cnt <= last_w ? '0 : w_cnt + W_W'(1);
            if (last_w) begin
                ch_cnt <= last_ch ? '0 : ch_cnt + CHG_W'(1);
                if (last_ch) begin
                    wb_cnt <= last_wb ? '0 : wb_cnt + W_W'(1);
                    if (last_wb) h_cnt <= last_h ? '0 : h_cnt + H_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CRD_W'(CREDIT_MAX);
        end else if (acc && !credit_vld) begin
            credit_cnt <= credit_cnt - CRD_W'(1);
        end else if (credit_vld && !acc && (credit_cnt != CRD_W'(CREDIT_MAX))) begin
            credit_cnt <= credit_cnt + CRD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_pd  <= '0;
            feat_vld <= 1'b0;
        end else begin
            feat_vld <= acc;
            if (acc) feat_pd <= PD_W'(rd_resp_pd);
        end
    end

    ln_delay_pipe #(.W(CHG_W), .LAT(WT_LAT)) u_wt_pipe (
        .clk     (clk),
        .rst     (rst),
        .en_in   (acc),
        .dat_in  (ch_cnt),
        .en_out  (rd_wt_en),
        .dat_out (rd_wt_addr)
    );

    ln_delay_pipe #(.W(CHG_W), .LAT(BIAS_LAT)) u_bias_pipe (
        .clk     (clk),
        .rst     (rst),
        .en_in   (acc && !rms_cfg),
        .dat_in  (ch_cnt),
        .en_out  (rd_bias_en),
        .dat_out (rd_bias_addr)
    );

endmodule
